// File: rtl/move_input_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_input_encoder_if                                                     |
// | Raw board buttons in, position-code strobe and multi-press strobe out.   |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
interface move_input_encoder_if;
  logic [8:0] buttons;
  logic [3:0] move_code;
  logic       move_valid;
  logic       multi_press_err;

  modport master (
    output buttons,
    input  move_code,
    input  move_valid,
    input  multi_press_err
  );

  modport slave (
    input  buttons,
    output move_code,
    output move_valid,
    output multi_press_err
  );
endinterface
`default_nettype wire

// File: rtl/move_input_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_input_encoder                                                        |
// | Synchronises and debounces 9 cell buttons, emits one position code per   |
// | press. Optional ERR_COUNT_EN adds a saturating multi-press counter.      |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module move_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 5
) (
  input  wire logic           clock,
  input  wire logic           reset,
  move_input_encoder_if.slave bus
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_EMIT         = 2'd1;
  localparam logic [1:0] S_WAIT_RELEASE = 2'd2;

  logic [8:0]       r_sync1;
  logic [8:0]       r_sync2;
  logic [8:0]       r_deb;
  logic [CNT_W-1:0] r_cnt [9];

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_move_code;
  logic             r_move_valid;
  logic             r_multi_err;
  logic [3:0]       w_move_code_nxt;
  logic             w_move_valid_nxt;
  logic             w_multi_err_nxt;

  logic             w_deb_any;
  logic             w_deb_onehot;
  logic [3:0]       w_deb_code;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.buttons;
      r_sync2 <= r_sync1;
    end
  end

  // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_deb <= '0;
      for (int i = 0; i < 9; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_LAST) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_deb_any    = |r_deb;
  assign w_deb_onehot = w_deb_any && ((r_deb & (r_deb - 9'd1)) == 9'd0);

  always_comb begin
    w_deb_code = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r_deb[i]) begin
        w_deb_code = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_move_code  <= 4'd0;
      r_move_valid <= 1'b0;
      r_multi_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_move_code  <= w_move_code_nxt;
      r_move_valid <= w_move_valid_nxt;
      r_multi_err  <= w_multi_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_deb_onehot) begin
          w_state_nxt = S_EMIT;
        end else if (w_deb_any) begin
          w_state_nxt = S_WAIT_RELEASE;
        end
      end
      S_EMIT:         w_state_nxt = S_WAIT_RELEASE;
      S_WAIT_RELEASE: begin
        if (!w_deb_any) begin
          w_state_nxt = S_IDLE;
        end
      end
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Next-cycle output values; strobes only ever originate from IDLE.
  always_comb begin
    w_move_code_nxt  = 4'd0;
    w_move_valid_nxt = 1'b0;
    w_multi_err_nxt  = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_deb_onehot) begin
        w_move_code_nxt  = w_deb_code;
        w_move_valid_nxt = 1'b1;
      end else if (w_deb_any) begin
        w_multi_err_nxt  = 1'b1;
      end
    end
  end

  assign bus.move_code       = r_move_code;
  assign bus.move_valid      = r_move_valid;
  assign bus.multi_press_err = r_multi_err;

`ifdef ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (w_multi_err_nxt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_move_input_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_move_input_encoder                                                     |
// | Directed scenarios plus random stimulus against a behavioural model.     |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_move_input_encoder;
  localparam int D = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  move_input_encoder_if bus_if ();
`ifdef ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  move_input_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
`ifdef ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a button counts as pressed once its input, seen two
  // clocks late, has disagreed with the pressed state for D straight clocks.
  logic [8:0] hist[$];
  logic [8:0] m_deb;
  logic [8:0] m_prev;
  logic       m_armed;
  int         m_hold;
  logic       m_valid;
  logic [3:0] m_code;
  logic       m_err;
  logic       m_all_diff;

  initial begin
    for (int k = 0; k < D + 2; k++) hist.push_front(9'd0);
    m_deb = 9'd0; m_armed = 1'b1; m_hold = 0;
    m_valid = 1'b0; m_code = 4'd0; m_err = 1'b0;
  end

  always @(posedge clock) begin
    m_prev = m_deb;
    m_valid = 1'b0; m_code = 4'd0; m_err = 1'b0;
    if (reset) begin
      m_deb = 9'd0; m_armed = 1'b1; m_hold = 0;
      hist[0] = 9'd0;
      hist.push_front(9'd0);
    end else begin
      if (m_armed) begin
        if ($countones(m_prev) == 1) begin
          m_valid = 1'b1;
          for (int i = 0; i < 9; i++) if (m_prev[i]) m_code = 4'(i + 1);
          m_armed = 1'b0; m_hold = 1;
        end else if ($countones(m_prev) > 1) begin
          m_err = 1'b1; m_armed = 1'b0; m_hold = 0;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (m_prev == 9'd0) begin
        m_armed = 1'b1;
      end
      for (int i = 0; i < 9; i++) begin
        m_all_diff = 1'b1;
        for (int k = 1; k <= D; k++) if (hist[k][i] == m_prev[i]) m_all_diff = 1'b0;
        if (m_all_diff) m_deb[i] = ~m_prev[i];
      end
      hist.push_front(bus_if.buttons);
    end
    while (hist.size() > D + 2) void'(hist.pop_back());
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  // Holds the current buttons for n clocks and records what came out.
  task automatic run_window(input int n, output int nvalid, output int first_at,
                            output logic [3:0] first_code, output int nerr);
    nvalid = 0; nerr = 0; first_at = -1; first_code = 4'd0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus_if.move_valid === 1'b1) begin
        if (nvalid == 0) begin
          first_at = k; first_code = bus_if.move_code;
        end
        nvalid++;
      end
      if (bus_if.multi_press_err === 1'b1) nerr++;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; bus_if.buttons = 9'h010;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus_if.move_code, bus_if.move_valid, bus_if.multi_press_err} !== 6'd0) begin
        errors++;
        $display("FAIL reset_outputs: got code=%0d valid=%b err=%b, expected all 0",
                 bus_if.move_code, bus_if.move_valid, bus_if.multi_press_err);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) begin
        checks++;
        if (bus_if.move_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_early_move: edge %0d got valid=%b, expected 0", k, bus_if.move_valid);
        end
      end else begin
        checks++;
        if (bus_if.move_valid !== 1'b1 || bus_if.move_code !== 4'd5) begin
          errors++;
          $display("FAIL reset_held_button: got valid=%b code=%0d, expected valid=1 code=5",
                   bus_if.move_valid, bus_if.move_code);
        end
      end
    end
    tick();
    checks++;
    if (bus_if.move_valid !== 1'b0 || bus_if.move_code !== 4'd0) begin
      errors++;
      $display("FAIL reset_pulse_width: got valid=%b code=%0d, expected 0/0",
               bus_if.move_valid, bus_if.move_code);
    end
    test_release("reset_release");
  endtask

  task automatic test_release(input string name);
    int nv, at, ne; logic [3:0] c;
    bus_if.buttons = 9'd0;
    run_window(14, nv, at, c, ne);
    checks++;
    if (nv != 0 || ne != 0) begin
      errors++;
      $display("FAIL %s: got %0d moves %0d errs, expected 0 and 0", name, nv, ne);
    end
  endtask

  task automatic test_single_press();
    int nv, at, ne; logic [3:0] c;
    bus_if.buttons = 9'h004;
    run_window(20, nv, at, c, ne);
    checks++;
    if (nv != 1 || at != 7 || c !== 4'd3) begin
      errors++;
      $display("FAIL single_press: got %0d moves at edge %0d code %0d, expected 1 at 7 code 3", nv, at, c);
    end
    test_release("single_release");
  endtask

  task automatic test_glitch();
    int nv1, nv2, at, ne1, ne2; logic [3:0] c;
    bus_if.buttons = 9'h001;
    run_window(3, nv1, at, c, ne1);
    bus_if.buttons = 9'h000;
    run_window(15, nv2, at, c, ne2);
    checks++;
    if (nv1 + nv2 != 0 || ne1 + ne2 != 0) begin
      errors++;
      $display("FAIL glitch_3cyc: got %0d moves, expected 0", nv1 + nv2);
    end
    bus_if.buttons = 9'h001;
    run_window(4, nv1, at, c, ne1);
    bus_if.buttons = 9'h000;
    run_window(15, nv2, at, c, ne2);
    checks++;
    if (nv1 != 0 || nv2 != 1 || c !== 4'd1) begin
      errors++;
      $display("FAIL glitch_4cyc: got %0d moves code %0d, expected 1 move code 1", nv1 + nv2, c);
    end
  endtask

  task automatic test_multi_press();
    int nv, at, ne; logic [3:0] c;
    bus_if.buttons = 9'h101;
    run_window(20, nv, at, c, ne);
    checks++;
    if (nv != 0 || ne != 1) begin
      errors++;
      $display("FAIL multi_press: got %0d moves %0d errs, expected 0 moves 1 err", nv, ne);
    end
    test_release("multi_release");
    bus_if.buttons = 9'h100;
    run_window(20, nv, at, c, ne);
    checks++;
    if (nv != 1 || c !== 4'd9) begin
      errors++;
      $display("FAIL multi_then_single: got %0d moves code %0d, expected 1 code 9", nv, c);
    end
    test_release("multi_single_release");
  endtask

  task automatic test_overlap();
    int nv, at, ne; logic [3:0] c;
    bus_if.buttons = 9'h008;
    run_window(10, nv, at, c, ne);
    checks++;
    if (nv != 1 || c !== 4'd4) begin
      errors++;
      $display("FAIL overlap_first: got %0d moves code %0d, expected 1 code 4", nv, c);
    end
    bus_if.buttons = 9'h048;
    run_window(10, nv, at, c, ne);
    checks++;
    if (nv != 0 || ne != 0) begin
      errors++;
      $display("FAIL overlap_second: got %0d moves %0d errs, expected 0 and 0", nv, ne);
    end
    test_release("overlap_release");
    bus_if.buttons = 9'h040;
    run_window(20, nv, at, c, ne);
    checks++;
    if (nv != 1 || c !== 4'd7) begin
      errors++;
      $display("FAIL overlap_fresh: got %0d moves code %0d, expected 1 code 7", nv, c);
    end
    test_release("overlap_fresh_release");
  endtask

  task automatic test_bounce();
    int nv, at, ne, nb; logic [3:0] c;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      bus_if.buttons = (((i / 2) % 2) == 0) ? 9'h002 : 9'h000;
      tick();
      if (bus_if.move_valid === 1'b1) nb++;
    end
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL bounce_quiet: got %0d moves during bounce, expected 0", nb);
    end
    bus_if.buttons = 9'h002;
    run_window(20, nv, at, c, ne);
    checks++;
    if (nv != 1 || c !== 4'd2) begin
      errors++;
      $display("FAIL bounce_hold: got %0d moves code %0d, expected 1 code 2", nv, c);
    end
    test_release("bounce_release");
  endtask

  task automatic test_random();
    int len, kind, shown;
    shown = 0;
    for (int seg = 0; seg < 90; seg++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       bus_if.buttons = 9'd0;
        1:       bus_if.buttons = 9'd1 << $urandom_range(0, 8);
        2:       bus_if.buttons = (9'd1 << $urandom_range(0, 8)) | (9'd1 << $urandom_range(0, 8));
        default: bus_if.buttons = 9'($urandom);
      endcase
      len = (kind == 0) ? $urandom_range(4, 14) : $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        tick();
        checks++;
        if (bus_if.move_valid !== m_valid || bus_if.move_code !== m_code ||
            bus_if.multi_press_err !== m_err) begin
          errors++;
          if (shown < 10) begin
            shown++;
            $display("FAIL random_vs_model: got valid=%b code=%0d err=%b, expected valid=%b code=%0d err=%b",
                     bus_if.move_valid, bus_if.move_code, bus_if.multi_press_err, m_valid, m_code, m_err);
          end
        end
      end
    end
    test_release("random_release");
  endtask

`ifdef ERR_COUNT_EN
  task automatic multi_event();
    bus_if.buttons = 9'h003;
    repeat (8) tick();
    bus_if.buttons = 9'h000;
    repeat (8) tick();
  endtask

  task automatic test_err_count();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL err_count_reset: got %0d, expected 0", err_count);
    end
    repeat (3) multi_event();
    checks++;
    if (err_count !== 8'd3) begin
      errors++;
      $display("FAIL err_count_three: got %0d, expected 3", err_count);
    end
    repeat (297) multi_event();
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL err_count_saturate: got %0d, expected 255", err_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_if.buttons = 9'd0;
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_press();
    test_overlap();
    test_bounce();
    test_random();
`ifdef ERR_COUNT_EN
    test_err_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
